bus_arbiter4: RTL

- Round-robin arbiter and sequencer for a shared 32-bit, 4-source bus whose data path is the team's 4-to-1 word mux.
- Up to 4 requesters present a word stream with a `last` marker.
- The arbiter grants one requester at a time, drives the mux select, and forwards beats to a single downstream consumer under valid/ready.
- It holds the grant for a whole burst, bounded by MAX_BEATS, so no requester starves.

---
 rtl/bus_arbiter4_pkg.sv | 17 +
 rtl/bus_arbiter4_rr_pick4.sv | 23 ++
 rtl/mux4to1.sv | 23 ++
 rtl/bus_arbiter4.sv | 136 +++++++++++++
 4 files changed

// File: rtl/bus_arbiter4_pkg.sv
// Shared types and constants for the 4-source round-robin bus arbiter.
package bus_arbiter4_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // One-hot decode of a source index.
  function automatic logic [NUM_SRC-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    return NUM_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter4_rr_pick4.sv
// Round-robin pick: first set request bit at or after i_start, wrapping 3 -> 0.
module rr_pick4
  import bus_arbiter4_pkg::*;
(
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [SEL_W-1:0]   i_start,
  output logic               o_found,
  output logic [SEL_W-1:0]   o_idx
);

  // Scan farthest offset first so the nearest set bit overwrites and wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = i_start;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (i_req[SEL_W'(i_start + SEL_W'(k))]) begin
        o_found = 1'b1;
        o_idx   = SEL_W'(i_start + SEL_W'(k));
      end
    end
  end

endmodule

// File: rtl/mux4to1.sv
// Generic 4-to-1 word multiplexer used as the shared bus data path.
module mux4to1 #(
  parameter int unsigned W = 32
) (
  input  logic [1:0]   i_sel,
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  input  logic [W-1:0] i_d2,
  input  logic [W-1:0] i_d3,
  output logic [W-1:0] o_y
);

  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin burst arbiter for a 4-source shared bus; holds grant per burst,
// bounded by MAX_BEATS, and forwards the owner's beats under valid/ready.
module bus_arbiter4
  import bus_arbiter4_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SRC-1:0]  req,
  input  logic [NUM_SRC-1:0]  last,
  input  logic [DATA_W-1:0]   data_a,
  input  logic [DATA_W-1:0]   data_b,
  input  logic [DATA_W-1:0]   data_c,
  input  logic [DATA_W-1:0]   data_d,
  input  logic                out_ready,
  output logic [NUM_SRC-1:0]  grant,
  output logic [SEL_W-1:0]    sel,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic                busy
);

  arb_state_e           r_state, w_state_nxt;
  logic [NUM_SRC-1:0]   r_grant, w_grant_nxt;
  logic [SEL_W-1:0]     r_sel,   w_sel_nxt;
  logic [SEL_W-1:0]     r_ptr,   w_ptr_nxt;
  logic [CNT_W-1:0]     r_cnt,   w_cnt_nxt;

  logic                 w_busy;
  logic                 w_owner_req;
  logic                 w_cnt_max;
  logic                 w_xfer;
  logic                 w_release;
  logic [SEL_W-1:0]     w_sel_inc;
  logic [NUM_SRC-1:0]   w_req_masked;
  logic                 w_idle_found, w_rel_found;
  logic [SEL_W-1:0]     w_idle_idx,   w_rel_idx;

  assign w_busy       = (r_state == BUSY);
  assign w_owner_req  = req[r_sel];
  assign w_cnt_max    = (r_cnt == CNT_W'(MAX_BEATS - 1));
  assign w_sel_inc    = SEL_W'(r_sel + SEL_W'(1));
  assign w_req_masked = req & ~idx_to_onehot(r_sel);

  assign out_valid = w_busy & w_owner_req;
  assign out_last  = w_busy & (last[r_sel] | w_cnt_max);
  assign w_xfer    = out_valid & out_ready;
  // Release on end of burst (natural or forced) or when the owner abandons its request.
  assign w_release = w_busy & ((w_xfer & out_last) | ~w_owner_req);

  rr_pick4 u_pick_idle (
    .i_req   (req),
    .i_start (r_ptr),
    .o_found (w_idle_found),
    .o_idx   (w_idle_idx)
  );

  rr_pick4 u_pick_rel (
    .i_req   (w_req_masked),
    .i_start (w_sel_inc),
    .o_found (w_rel_found),
    .o_idx   (w_rel_idx)
  );

  mux4to1 #(.W(DATA_W)) u_mux (
    .i_sel (r_sel),
    .i_d0  (data_a),
    .i_d1  (data_b),
    .i_d2  (data_c),
    .i_d3  (data_d),
    .o_y   (out_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_idle_found) begin
          w_state_nxt = BUSY;
          w_grant_nxt = idx_to_onehot(w_idle_idx);
          w_sel_nxt   = w_idle_idx;
          w_cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (w_release) begin
          w_ptr_nxt = w_sel_inc;
          // Back-to-back handover avoids a bubble when another source is waiting.
          if (w_rel_found) begin
            w_grant_nxt = idx_to_onehot(w_rel_idx);
            w_sel_nxt   = w_rel_idx;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
          end
        end else if (w_xfer) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  assign grant = r_grant;
  assign sel   = r_sel;
  assign busy  = w_busy;

endmodule
